// File: rtl/mem_access_arbiter_if.sv
// Purpose: bundles the fetch and data request/return signals with the external memory bus of the arbiter.
// Latency: none; this is a signal bundle only.
// Backpressure: MEM_WAIT tells requesters to hold their requests; BUS_ACK completes each bus transfer.
interface mem_access_arbiter_if;
    // instruction fetch side
    logic        INST_RDEN;
    logic [31:0] INST_RADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        INST_FLUSH;

    // data read/write side
    logic        DATA_RDEN;
    logic [31:0] DATA_RADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WDATA;

    // shared stall towards fetch unit and pipeline
    logic        MEM_WAIT;

    // external memory bus
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_STRB;
    logic [31:0] BUS_WDATA;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        BUS_ERR;

    // master: the arbiter, which owns the memory bus and the return path
    modport master (
        input  INST_RDEN, INST_RADDR, INST_FLUSH,
        input  DATA_RDEN, DATA_RADDR, DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
        input  BUS_ACK, BUS_RDATA,
        output INST_RVALID, INST_RDATA, DATA_RVALID, DATA_RDATA, MEM_WAIT,
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_STRB, BUS_WDATA, BUS_ERR
    );

    // slave: the requesters and the memory on the far side of the arbiter
    modport slave (
        output INST_RDEN, INST_RADDR, INST_FLUSH,
        output DATA_RDEN, DATA_RADDR, DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
        output BUS_ACK, BUS_RDATA,
        input  INST_RVALID, INST_RDATA, DATA_RVALID, DATA_RDATA, MEM_WAIT,
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_STRB, BUS_WDATA, BUS_ERR
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Purpose: serialises fetch, data read and data write requests onto one external memory port (write > data read > fetch).
// Latency: accept edge E -> BUS_REQ in E+1; ack in E+1 -> RVALID pulse and MEM_WAIT low in E+2.
// Backpressure: registered MEM_WAIT blocks new acceptance while any slot is pending or the bus is busy; BUS_REQ holds until BUS_ACK or timeout.
module mem_access_arbiter #(
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_WIDTH   = 9
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_access_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DREAD = 2'd2,
        IREAD = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_slot_t;

    // Counter value seen on the last cycle a request may wait before it is aborted.
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        (ACK_TIMEOUT == 0) ? '0 : CNT_WIDTH'(ACK_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   i_squash_q;

    // pending slots, one per requester
    logic                   w_vld_q, d_vld_q, i_vld_q;
    logic                   w_vld_d, d_vld_d, i_vld_d;
    wr_slot_t               w_slot_q;
    logic [31:0]            d_addr_q;
    logic [31:0]            i_addr_q;

    // return path and status registers
    logic                   inst_rvalid_q, data_rvalid_q;
    logic [31:0]            inst_rdata_q, data_rdata_q;
    logic                   mem_wait_q;
    logic                   bus_err_q;

    logic                   busy, ack_hit, to_hit, done;
    logic                   accept, acc_w, acc_d, acc_i;
    logic                   fin_w, fin_d, fin_i;
    logic                   i_flush_pending, i_drop;

    // A transfer finishes on ack, or on timeout when no ack arrives on the last allowed cycle.
    assign busy    = (state_q != IDLE);
    assign ack_hit = busy & bus.BUS_ACK;
    assign to_hit  = (ACK_TIMEOUT != 0) && busy && !bus.BUS_ACK && (cnt_q == TO_LAST);
    assign done    = ack_hit | to_hit;

    // New requests are only taken while the arbiter is fully idle; a fetch raised with FLUSH is dropped.
    assign accept  = ~mem_wait_q;
    assign acc_w   = accept & bus.DATA_WREN;
    assign acc_d   = accept & bus.DATA_RDEN;
    assign acc_i   = accept & bus.INST_RDEN & ~bus.INST_FLUSH;

    assign fin_w   = done & (state_q == WRITE);
    assign fin_d   = done & (state_q == DREAD);
    assign fin_i   = done & (state_q == IREAD);

    // FLUSH only removes a fetch that has not reached the bus; an in-flight fetch runs to completion silently.
    assign i_flush_pending = bus.INST_FLUSH & (state_q != IREAD);
    assign i_drop          = i_squash_q | bus.INST_FLUSH;

    // The slot being served stays occupied until its transfer finishes, so it keeps driving the bus.
    assign w_vld_d = (w_vld_q & ~fin_w) | acc_w;
    assign d_vld_d = (d_vld_q & ~fin_d) | acc_d;
    assign i_vld_d = (i_vld_q & ~fin_i & ~i_flush_pending) | acc_i;

    // Next state: pick the highest-priority occupied slot whenever the bus is free or a transfer ends.
    always_comb begin
        state_d = state_q;
        if (!busy || done) begin
            if (w_vld_d) begin
                state_d = WRITE;
            end else if (d_vld_d) begin
                state_d = DREAD;
            end else if (i_vld_d) begin
                state_d = IREAD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter restarts for every new transfer; squash flag remembers a FLUSH seen during an in-flight fetch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            i_squash_q <= 1'b0;
        end else begin
            if (!busy || done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            i_squash_q <= (state_q == IREAD) && !done && (i_squash_q || bus.INST_FLUSH);
        end
    end

    // Pending slot occupancy and captured request fields.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_vld_q  <= 1'b0;
            d_vld_q  <= 1'b0;
            i_vld_q  <= 1'b0;
            w_slot_q <= '0;
            d_addr_q <= '0;
            i_addr_q <= '0;
        end else begin
            w_vld_q <= w_vld_d;
            d_vld_q <= d_vld_d;
            i_vld_q <= i_vld_d;
            if (acc_w) begin
                w_slot_q <= '{addr: bus.DATA_WADDR, strb: bus.DATA_WSTRB, data: bus.DATA_WDATA};
            end
            if (acc_d) begin
                d_addr_q <= bus.DATA_RADDR;
            end
            if (acc_i) begin
                i_addr_q <= bus.INST_RADDR;
            end
        end
    end

    // Read return: one-cycle valid pulses, data held until the next completion, zero data on timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
            bus_err_q     <= 1'b0;
            mem_wait_q    <= 1'b0;
        end else begin
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            bus_err_q     <= to_hit;
            mem_wait_q    <= w_vld_d | d_vld_d | i_vld_d | (state_d != IDLE);
            if (fin_d) begin
                data_rvalid_q <= 1'b1;
                data_rdata_q  <= ack_hit ? bus.BUS_RDATA : '0;
            end
            if (fin_i && !i_drop) begin
                inst_rvalid_q <= 1'b1;
                inst_rdata_q  <= ack_hit ? bus.BUS_RDATA : '0;
            end
        end
    end

    // Bus drive: fields come straight from the served slot so they stay stable until the transfer ends.
    always_comb begin
        bus.BUS_REQ   = 1'b0;
        bus.BUS_WE    = 1'b0;
        bus.BUS_ADDR  = '0;
        bus.BUS_STRB  = '0;
        bus.BUS_WDATA = '0;
        case (state_q)
            WRITE: begin
                bus.BUS_REQ   = 1'b1;
                bus.BUS_WE    = 1'b1;
                bus.BUS_ADDR  = w_slot_q.addr;
                bus.BUS_STRB  = w_slot_q.strb;
                bus.BUS_WDATA = w_slot_q.data;
            end
            DREAD: begin
                bus.BUS_REQ   = 1'b1;
                bus.BUS_ADDR  = d_addr_q;
                bus.BUS_STRB  = 4'hf;
            end
            IREAD: begin
                bus.BUS_REQ   = 1'b1;
                bus.BUS_ADDR  = i_addr_q;
                bus.BUS_STRB  = 4'hf;
            end
            default: begin
            end
        endcase
    end

    assign bus.INST_RVALID = inst_rvalid_q;
    assign bus.INST_RDATA  = inst_rdata_q;
    assign bus.DATA_RVALID = data_rvalid_q;
    assign bus.DATA_RDATA  = data_rdata_q;
    assign bus.MEM_WAIT    = mem_wait_q;
    assign bus.BUS_ERR     = bus_err_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Purpose: self-checking bench for mem_access_arbiter: directed scenarios plus randomized traffic against a priority-queue model.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: the bench plays memory, choosing ack delays, and keeps junk requests up while MEM_WAIT is high.
module tb_mem_access_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 write, 1 data read, 2 fetch
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    mem_access_arbiter_if m ();
    mem_access_arbiter_if t ();

    mem_access_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (m)
    );

    mem_access_arbiter #(.ACK_TIMEOUT(4), .CNT_WIDTH(3)) dut_to (
        .CLK (CLK),
        .RST (RST),
        .bus (t)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        m.INST_RDEN = 0; m.INST_RADDR = 0; m.INST_FLUSH = 0;
        m.DATA_RDEN = 0; m.DATA_RADDR = 0; m.DATA_WREN = 0;
        m.DATA_WADDR = 0; m.DATA_WSTRB = 0; m.DATA_WDATA = 0;
        m.BUS_ACK = 0; m.BUS_RDATA = 0;
        t.INST_RDEN = 0; t.INST_RADDR = 0; t.INST_FLUSH = 0;
        t.DATA_RDEN = 0; t.DATA_RADDR = 0; t.DATA_WREN = 0;
        t.DATA_WADDR = 0; t.DATA_WSTRB = 0; t.DATA_WDATA = 0;
        t.BUS_ACK = 0; t.BUS_RDATA = 0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) step();
        n_chk++; if ({m.BUS_REQ, m.MEM_WAIT, m.INST_RVALID, m.DATA_RVALID, m.BUS_ERR} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {m.BUS_REQ, m.MEM_WAIT, m.INST_RVALID, m.DATA_RVALID, m.BUS_ERR}); else n_pass++;
        n_chk++; if ({m.BUS_WE, m.BUS_ADDR, m.BUS_STRB, m.BUS_WDATA} !== 69'h0)
            $display("FAIL reset_bus: got %h want 0", {m.BUS_WE, m.BUS_ADDR, m.BUS_STRB, m.BUS_WDATA}); else n_pass++;
        n_chk++; if ({m.INST_RDATA, m.DATA_RDATA} !== 64'h0)
            $display("FAIL reset_rdata: got %h want 0", {m.INST_RDATA, m.DATA_RDATA}); else n_pass++;
        RST = 1'b0;
        step();
        n_chk++; if ({m.BUS_REQ, m.MEM_WAIT, t.BUS_REQ, t.MEM_WAIT} !== 4'b0)
            $display("FAIL reset_release: got %b want 0000", {m.BUS_REQ, m.MEM_WAIT, t.BUS_REQ, t.MEM_WAIT}); else n_pass++;
    endtask

    task automatic test_single_fetch;
        m.INST_RDEN = 1; m.INST_RADDR = 32'h0000_0010;
        step();                                   // cycle E+1
        m.INST_RDEN = 0;
        n_chk++; if ({m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB} !== {1'b1, 1'b0, 32'h10, 4'hf})
            $display("FAIL fetch_bus: got %h want %h", {m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB}, {1'b1, 1'b0, 32'h10, 4'hf}); else n_pass++;
        n_chk++; if ({m.MEM_WAIT, m.INST_RVALID} !== 2'b10)
            $display("FAIL fetch_wait_e1: got %b want 10", {m.MEM_WAIT, m.INST_RVALID}); else n_pass++;
        m.BUS_ACK = 1; m.BUS_RDATA = 32'h0000_0013;
        step();                                   // cycle E+2
        m.BUS_ACK = 0;
        n_chk++; if ({m.INST_RVALID, m.INST_RDATA} !== {1'b1, 32'h13})
            $display("FAIL fetch_ret: got %h want %h", {m.INST_RVALID, m.INST_RDATA}, {1'b1, 32'h13}); else n_pass++;
        n_chk++; if ({m.MEM_WAIT, m.BUS_REQ, m.DATA_RVALID} !== 3'b000)
            $display("FAIL fetch_e2_idle: got %b want 000", {m.MEM_WAIT, m.BUS_REQ, m.DATA_RVALID}); else n_pass++;
        step();
        n_chk++; if ({m.INST_RVALID, m.INST_RDATA} !== {1'b0, 32'h13})
            $display("FAIL fetch_pulse_hold: got %h want %h", {m.INST_RVALID, m.INST_RDATA}, {1'b0, 32'h13}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        m.DATA_WREN = 1; m.DATA_WADDR = 32'h100; m.DATA_WSTRB = 4'h3; m.DATA_WDATA = 32'hdeadbeef;
        m.DATA_RDEN = 1; m.DATA_RADDR = 32'h200;
        m.INST_RDEN = 1; m.INST_RADDR = 32'h0;
        step();
        clear_inputs();
        n_chk++; if ({m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB, m.BUS_WDATA} !== {1'b1, 1'b1, 32'h100, 4'h3, 32'hdeadbeef})
            $display("FAIL b2b_write: got %h want %h", {m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB, m.BUS_WDATA}, {1'b1, 1'b1, 32'h100, 4'h3, 32'hdeadbeef}); else n_pass++;
        m.BUS_ACK = 1;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB} !== {1'b1, 1'b0, 32'h200, 4'hf})
            $display("FAIL b2b_dread: got %h want %h", {m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB}, {1'b1, 1'b0, 32'h200, 4'hf}); else n_pass++;
        n_chk++; if ({m.DATA_RVALID, m.INST_RVALID, m.MEM_WAIT} !== 3'b001)
            $display("FAIL b2b_after_write: got %b want 001", {m.DATA_RVALID, m.INST_RVALID, m.MEM_WAIT}); else n_pass++;
        m.BUS_ACK = 1; m.BUS_RDATA = 32'h1111_2222;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.DATA_RVALID, m.DATA_RDATA} !== {1'b1, 32'h1111_2222})
            $display("FAIL b2b_dret: got %h want %h", {m.DATA_RVALID, m.DATA_RDATA}, {1'b1, 32'h1111_2222}); else n_pass++;
        n_chk++; if ({m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB} !== {1'b1, 1'b0, 32'h0, 4'hf})
            $display("FAIL b2b_iread: got %h want %h", {m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB}, {1'b1, 1'b0, 32'h0, 4'hf}); else n_pass++;
        m.BUS_ACK = 1; m.BUS_RDATA = 32'h3333_4444;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.INST_RVALID, m.INST_RDATA, m.DATA_RVALID} !== {1'b1, 32'h3333_4444, 1'b0})
            $display("FAIL b2b_iret: got %h want %h", {m.INST_RVALID, m.INST_RDATA, m.DATA_RVALID}, {1'b1, 32'h3333_4444, 1'b0}); else n_pass++;
        n_chk++; if ({m.BUS_REQ, m.MEM_WAIT} !== 2'b00)
            $display("FAIL b2b_end: got %b want 00", {m.BUS_REQ, m.MEM_WAIT}); else n_pass++;
    endtask

    task automatic test_ack_delay;
        m.DATA_RDEN = 1; m.DATA_RADDR = 32'h0000_0abc;
        step();
        m.DATA_RDEN = 0;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if ({m.BUS_REQ, m.BUS_ADDR, m.MEM_WAIT, m.DATA_RVALID} !== {1'b1, 32'habc, 1'b1, 1'b0})
                $display("FAIL delay_wait%0d: got %h want %h", i, {m.BUS_REQ, m.BUS_ADDR, m.MEM_WAIT, m.DATA_RVALID}, {1'b1, 32'habc, 1'b1, 1'b0}); else n_pass++;
            step();
        end
        n_chk++; if ({m.BUS_REQ, m.BUS_ADDR, m.MEM_WAIT} !== {1'b1, 32'habc, 1'b1})
            $display("FAIL delay_ackcyc: got %h want %h", {m.BUS_REQ, m.BUS_ADDR, m.MEM_WAIT}, {1'b1, 32'habc, 1'b1}); else n_pass++;
        m.BUS_ACK = 1; m.BUS_RDATA = 32'hcafe_f00d;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.DATA_RVALID, m.DATA_RDATA, m.MEM_WAIT} !== {1'b1, 32'hcafe_f00d, 1'b0})
            $display("FAIL delay_ret: got %h want %h", {m.DATA_RVALID, m.DATA_RDATA, m.MEM_WAIT}, {1'b1, 32'hcafe_f00d, 1'b0}); else n_pass++;
        step();
        n_chk++; if (m.DATA_RVALID !== 1'b0)
            $display("FAIL delay_pulse: got %b want 0", m.DATA_RVALID); else n_pass++;
    endtask

    task automatic test_flush;
        // flush while the fetch is already on the bus
        m.INST_RDEN = 1; m.INST_RADDR = 32'h40;
        step();
        m.INST_RDEN = 0;
        m.INST_FLUSH = 1;
        step();
        m.INST_FLUSH = 0;
        n_chk++; if ({m.BUS_REQ, m.BUS_ADDR, m.INST_RVALID} !== {1'b1, 32'h40, 1'b0})
            $display("FAIL flush_inflight_bus: got %h want %h", {m.BUS_REQ, m.BUS_ADDR, m.INST_RVALID}, {1'b1, 32'h40, 1'b0}); else n_pass++;
        m.BUS_ACK = 1; m.BUS_RDATA = 32'h77;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.INST_RVALID, m.BUS_REQ, m.MEM_WAIT} !== 3'b000)
            $display("FAIL flush_inflight_ret: got %b want 000", {m.INST_RVALID, m.BUS_REQ, m.MEM_WAIT}); else n_pass++;
        step();
        n_chk++; if (m.INST_RVALID !== 1'b0)
            $display("FAIL flush_inflight_late: got %b want 0", m.INST_RVALID); else n_pass++;

        // flush while the fetch waits behind a write
        m.DATA_WREN = 1; m.DATA_WADDR = 32'h300; m.DATA_WSTRB = 4'hf; m.DATA_WDATA = 32'h1;
        m.INST_RDEN = 1; m.INST_RADDR = 32'h80;
        step();
        clear_inputs();
        n_chk++; if ({m.BUS_REQ, m.BUS_WE, m.BUS_ADDR} !== {1'b1, 1'b1, 32'h300})
            $display("FAIL flush_pend_write: got %h want %h", {m.BUS_REQ, m.BUS_WE, m.BUS_ADDR}, {1'b1, 1'b1, 32'h300}); else n_pass++;
        m.INST_FLUSH = 1;
        step();
        m.INST_FLUSH = 0;
        m.BUS_ACK = 1;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.BUS_REQ, m.MEM_WAIT} !== 2'b00)
            $display("FAIL flush_pend_dropped: got %b want 00", {m.BUS_REQ, m.MEM_WAIT}); else n_pass++;
        step();
        n_chk++; if ({m.BUS_REQ, m.INST_RVALID} !== 2'b00)
            $display("FAIL flush_pend_late: got %b want 00", {m.BUS_REQ, m.INST_RVALID}); else n_pass++;

        // fetch raised on the same edge as a flush is never accepted
        m.INST_RDEN = 1; m.INST_RADDR = 32'hc0; m.INST_FLUSH = 1;
        step();
        clear_inputs();
        n_chk++; if ({m.BUS_REQ, m.MEM_WAIT} !== 2'b00)
            $display("FAIL flush_same_edge: got %b want 00", {m.BUS_REQ, m.MEM_WAIT}); else n_pass++;
    endtask

    task automatic test_random(input int iters);
        txn_t        q[$];
        txn_t        tx;
        bit          dw, dr, df;
        logic [31:0] wa, wd, ra, ia, rd;
        logic [3:0]  ws;
        int          wl;
        bit          exp_dv, exp_iv, seen_d, seen_i;
        logic [31:0] exp_dd, exp_id;
        seen_d = 0; seen_i = 0; exp_dd = 0; exp_id = 0;
        for (int it = 0; it < iters; it++) begin
            do begin
                dw = 1'($urandom_range(0, 1));
                dr = 1'($urandom_range(0, 1));
                df = 1'($urandom_range(0, 1));
            end while (!(dw || dr || df));
            wa = $urandom; wd = $urandom; ws = 4'($urandom); ra = $urandom; ia = $urandom;
            // model: all simultaneous requests are served write, then data read, then fetch
            q.delete();
            if (dw) begin tx.kind = 2'd0; tx.we = 1'b1; tx.addr = wa; tx.strb = ws;   tx.wdata = wd; q.push_back(tx); end
            if (dr) begin tx.kind = 2'd1; tx.we = 1'b0; tx.addr = ra; tx.strb = 4'hf; tx.wdata = 0;  q.push_back(tx); end
            if (df) begin tx.kind = 2'd2; tx.we = 1'b0; tx.addr = ia; tx.strb = 4'hf; tx.wdata = 0;  q.push_back(tx); end
            m.DATA_WREN = dw; m.DATA_WADDR = wa; m.DATA_WSTRB = ws; m.DATA_WDATA = wd;
            m.DATA_RDEN = dr; m.DATA_RADDR = ra;
            m.INST_RDEN = df; m.INST_RADDR = ia;
            step();
            exp_dv = 0; exp_iv = 0;
            wl = int'($urandom_range(0, 3));
            for (int cyc = 0; cyc < 64; cyc++) begin
                n_chk++; if ({m.DATA_RVALID, m.INST_RVALID} !== {exp_dv, exp_iv})
                    $display("FAIL rnd_valid it%0d: got %b want %b", it, {m.DATA_RVALID, m.INST_RVALID}, {exp_dv, exp_iv}); else n_pass++;
                if (seen_d) begin
                    n_chk++; if (m.DATA_RDATA !== exp_dd)
                        $display("FAIL rnd_drdata it%0d: got %h want %h", it, m.DATA_RDATA, exp_dd); else n_pass++;
                end
                if (seen_i) begin
                    n_chk++; if (m.INST_RDATA !== exp_id)
                        $display("FAIL rnd_irdata it%0d: got %h want %h", it, m.INST_RDATA, exp_id); else n_pass++;
                end
                if (q.size() == 0) begin
                    n_chk++; if ({m.BUS_REQ, m.MEM_WAIT} !== 2'b00)
                        $display("FAIL rnd_idle it%0d: got %b want 00", it, {m.BUS_REQ, m.MEM_WAIT}); else n_pass++;
                    break;
                end
                n_chk++; if ({m.MEM_WAIT, m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB} !== {2'b11, q[0].we, q[0].addr, q[0].strb})
                    $display("FAIL rnd_bus it%0d: got %h want %h", it, {m.MEM_WAIT, m.BUS_REQ, m.BUS_WE, m.BUS_ADDR, m.BUS_STRB}, {2'b11, q[0].we, q[0].addr, q[0].strb}); else n_pass++;
                if (q[0].we) begin
                    n_chk++; if (m.BUS_WDATA !== q[0].wdata)
                        $display("FAIL rnd_wdata it%0d: got %h want %h", it, m.BUS_WDATA, q[0].wdata); else n_pass++;
                end
                // requests raised while busy must be ignored
                m.DATA_WREN = 1'($urandom); m.DATA_WADDR = $urandom; m.DATA_WDATA = $urandom;
                m.DATA_RDEN = 1'($urandom); m.DATA_RADDR = $urandom;
                m.INST_RDEN = 1'($urandom); m.INST_RADDR = $urandom;
                rd = $urandom;
                m.BUS_RDATA = rd;
                if (wl == 0) begin
                    m.BUS_ACK = 1;
                    exp_dv = (q[0].kind == 2'd1);
                    exp_iv = (q[0].kind == 2'd2);
                    if (exp_dv) begin exp_dd = rd; seen_d = 1; end
                    if (exp_iv) begin exp_id = rd; seen_i = 1; end
                    void'(q.pop_front());
                    wl = int'($urandom_range(0, 3));
                end else begin
                    m.BUS_ACK = 0;
                    exp_dv = 0; exp_iv = 0;
                    wl--;
                end
                step();
                m.BUS_ACK = 0;
            end
            clear_inputs();
            if (q.size() != 0) begin
                n_chk++;
                $display("FAIL rnd_budget it%0d: got %0d pending want 0", it, q.size());
            end
        end
    endtask

    task automatic test_timeout;
        int req_cycles;
        // normal read to leave nonzero return data behind
        t.DATA_RDEN = 1; t.DATA_RADDR = 32'h500;
        step();
        t.DATA_RDEN = 0;
        t.BUS_ACK = 1; t.BUS_RDATA = 32'h5a5a_5a5a;
        step();
        t.BUS_ACK = 0;
        n_chk++; if ({t.DATA_RVALID, t.DATA_RDATA} !== {1'b1, 32'h5a5a_5a5a})
            $display("FAIL to_pre_read: got %h want %h", {t.DATA_RVALID, t.DATA_RDATA}, {1'b1, 32'h5a5a_5a5a}); else n_pass++;
        // unanswered read
        t.DATA_RDEN = 1; t.DATA_RADDR = 32'h600;
        step();
        t.DATA_RDEN = 0;
        req_cycles = 0;
        for (int i = 0; i < 12 && t.BUS_REQ === 1'b1; i++) begin
            n_chk++; if ({t.BUS_ERR, t.BUS_ADDR} !== {1'b0, 32'h600})
                $display("FAIL to_wait%0d: got %h want %h", i, {t.BUS_ERR, t.BUS_ADDR}, {1'b0, 32'h600}); else n_pass++;
            req_cycles++;
            step();
        end
        n_chk++; if (req_cycles !== 4)
            $display("FAIL to_req_len: got %0d want 4", req_cycles); else n_pass++;
        n_chk++; if ({t.BUS_ERR, t.DATA_RVALID, t.DATA_RDATA} !== {2'b11, 32'h0})
            $display("FAIL to_abort: got %h want %h", {t.BUS_ERR, t.DATA_RVALID, t.DATA_RDATA}, {2'b11, 32'h0}); else n_pass++;
        n_chk++; if ({t.BUS_REQ, t.MEM_WAIT} !== 2'b00)
            $display("FAIL to_idle: got %b want 00", {t.BUS_REQ, t.MEM_WAIT}); else n_pass++;
        step();
        n_chk++; if ({t.BUS_ERR, t.DATA_RVALID} !== 2'b00)
            $display("FAIL to_pulse: got %b want 00", {t.BUS_ERR, t.DATA_RVALID}); else n_pass++;
        // next request behaves normally
        t.INST_RDEN = 1; t.INST_RADDR = 32'h700;
        step();
        t.INST_RDEN = 0;
        n_chk++; if ({t.BUS_REQ, t.BUS_ADDR} !== {1'b1, 32'h700})
            $display("FAIL to_next_bus: got %h want %h", {t.BUS_REQ, t.BUS_ADDR}, {1'b1, 32'h700}); else n_pass++;
        t.BUS_ACK = 1; t.BUS_RDATA = 32'h99;
        step();
        t.BUS_ACK = 0;
        n_chk++; if ({t.INST_RVALID, t.INST_RDATA, t.BUS_ERR} !== {1'b1, 32'h99, 1'b0})
            $display("FAIL to_next_ret: got %h want %h", {t.INST_RVALID, t.INST_RDATA, t.BUS_ERR}, {1'b1, 32'h99, 1'b0}); else n_pass++;
    endtask

    task automatic test_reset_mid;
        m.INST_RDEN = 1; m.INST_RADDR = 32'h20;
        step();
        m.INST_RDEN = 0;
        n_chk++; if ({m.BUS_REQ, m.BUS_ADDR} !== {1'b1, 32'h20})
            $display("FAIL rstmid_pre: got %h want %h", {m.BUS_REQ, m.BUS_ADDR}, {1'b1, 32'h20}); else n_pass++;
        #2;
        RST = 1'b1;
        #1;
        n_chk++; if ({m.BUS_REQ, m.MEM_WAIT, m.BUS_ADDR} !== {2'b00, 32'h0})
            $display("FAIL rstmid_drop: got %h want 0", {m.BUS_REQ, m.MEM_WAIT, m.BUS_ADDR}); else n_pass++;
        n_chk++; if (m.INST_RDATA !== 32'h0)
            $display("FAIL rstmid_rdata: got %h want 0", m.INST_RDATA); else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        step();
        m.BUS_ACK = 1; m.BUS_RDATA = 32'h1234;
        step();
        m.BUS_ACK = 0;
        n_chk++; if ({m.INST_RVALID, m.DATA_RVALID, m.BUS_REQ, m.MEM_WAIT, m.BUS_ERR} !== 5'b0)
            $display("FAIL rstmid_late_ack: got %b want 00000", {m.INST_RVALID, m.DATA_RVALID, m.BUS_REQ, m.MEM_WAIT, m.BUS_ERR}); else n_pass++;
        step();
        n_chk++; if ({m.INST_RVALID, m.INST_RDATA} !== {1'b0, 32'h0})
            $display("FAIL rstmid_after: got %h want 0", {m.INST_RVALID, m.INST_RDATA}); else n_pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_ack_delay();
        test_flush();
        test_random(40);
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
